mod_instruction_fetch: RTL and testbench

//   Requester side of the combinational instruction ROM port. Holds the program counter and drives the ROM

---
 rtl/mod_instruction_fetch.sv | 120 ++++++++++++
 tb/tb_mod_instruction_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_instruction_fetch.sv
// Instruction fetch stage: owns the program counter, addresses a combinational
// instruction ROM and registers each returned word into a one-entry fetch
// buffer handed to decode via valid/ready. Handles redirects and halts when
// the ROM reports end-of-program.
module mod_instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        rom_mem_end,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        if_valid_r;
    logic [31:0] if_instruction_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc_plus4_r;
    logic        fetch_halted_r;
    logic [31:0] fetch_count_r;

    logic        can_load_s;
    logic        deliver_s;

    // Buffer can take a new word when empty or being drained this cycle;
    // a redirect discards the buffered word so it is never counted.
    assign can_load_s  = !if_valid_r || if_ready;
    assign deliver_s   = if_valid_r && if_ready && !redirect_valid;

    assign rom_address    = pc_r[31:2];
    assign if_valid       = if_valid_r;
    assign if_instruction = if_instruction_r;
    assign if_pc          = if_pc_r;
    assign if_pc_plus4    = if_pc_plus4_r;
    assign fetch_halted   = fetch_halted_r;
    assign fetch_count    = fetch_count_r;

    // Fetch FSM, program counter, fetch buffer and delivery counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_RUN;
            pc_r             <= RESET_PC & WORD_MASK;
            if_valid_r       <= 1'b0;
            if_instruction_r <= 32'h0000_0000;
            if_pc_r          <= 32'h0000_0000;
            if_pc_plus4_r    <= 32'h0000_0004;
            fetch_halted_r   <= 1'b0;
            fetch_count_r    <= 32'h0000_0000;
        end else begin
            // Saturating count of words actually accepted by decode.
            if (deliver_s && (fetch_count_r != COUNT_MAX)) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end

            if (redirect_valid) begin
                // Redirect wins over everything, including HALT (resume).
                pc_r           <= redirect_target & WORD_MASK;
                if_valid_r     <= 1'b0;
                state_r        <= ST_RUN;
                fetch_halted_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (can_load_s) begin
                            if (rom_mem_end) begin
                                // pc holds at the end address while halted.
                                state_r        <= ST_HALT;
                                if_valid_r     <= 1'b0;
                                fetch_halted_r <= 1'b1;
                            end else begin
                                if_instruction_r <= rom_instruction;
                                if_pc_r          <= pc_r;
                                if_pc_plus4_r    <= pc_r + 32'd4;
                                if_valid_r       <= 1'b1;
                                pc_r             <= pc_r + 32'd4;
                                fetch_halted_r   <= 1'b0;
                            end
                        end else begin
                            // Stall: ROM not sampled, everything holds.
                            fetch_halted_r <= 1'b0;
                        end
                    end
                    ST_HALT: begin
                        if (if_valid_r && if_ready) begin
                            if_valid_r     <= 1'b0;
                            fetch_halted_r <= 1'b1;
                        end else begin
                            fetch_halted_r <= !if_valid_r;
                        end
                    end
                    default: begin
                        state_r        <= ST_RUN;
                        if_valid_r     <= 1'b0;
                        fetch_halted_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Self-checking bench for mod_instruction_fetch: directed scenarios with
// literal expectations followed by randomized ready/redirect/reset traffic,
// all compared every cycle against a behavioural fetch model.
module tb_mod_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] rom_address;
    logic [31:0] rom_instruction;
    logic        rom_mem_end;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_halted;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc     = 32'h0;
    logic        m_halt   = 1'b0;
    logic        m_valid  = 1'b0;
    logic [31:0] m_bpc    = 32'h0;
    logic [31:0] m_binstr = 32'h0;
    logic [31:0] m_count  = 32'h0;

    always #5 clk = ~clk;

    // Program: 44 words at the bottom plus 16 words at the top of memory.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'd0:   return 32'h0000_0022;
            30'd1:   return 32'h2001_0001;
            30'd5:   return 32'h0041_1820;
            default: return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic logic mem_end(input logic [29:0] a);
        return (a >= 30'd44) && (a < 30'h3FFF_FFF0);
    endfunction

    assign rom_instruction = rom_word(rom_address);
    assign rom_mem_end     = mem_end(rom_address);

    mod_instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .rom_mem_end     (rom_mem_end),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .fetch_halted    (fetch_halted),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock of the fetch contract, evaluated from the inputs present at the edge.
    task automatic model_step();
        if (!rst_n) begin
            m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0;
            m_bpc = 32'h0; m_binstr = 32'h0; m_count = 32'h0;
        end else begin
            if (m_valid && if_ready && !redirect_valid && m_count != 32'hFFFF_FFFF)
                m_count = m_count + 1;
            if (redirect_valid) begin
                m_pc = {redirect_target[31:2], 2'b00};
                m_valid = 1'b0;
                m_halt = 1'b0;
            end else if (!m_halt && (!m_valid || if_ready)) begin
                if (mem_end(m_pc[31:2])) begin
                    m_halt = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_bpc = m_pc;
                    m_binstr = rom_word(m_pc[31:2]);
                    m_valid = 1'b1;
                    m_pc = m_pc + 4;
                end
            end else if (m_halt && m_valid && if_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("rom_address",    {2'b00, rom_address}, {2'b00, m_pc[31:2]});
        check("if_valid",       {31'd0, if_valid},     {31'd0, m_valid});
        check("if_pc",          if_pc,                 m_bpc);
        check("if_instruction", if_instruction,        m_binstr);
        check("if_pc_plus4",    if_pc_plus4,           m_bpc + 32'd4);
        check("fetch_halted",   {31'd0, fetch_halted}, {31'd0, m_halt && !m_valid});
        check("fetch_count",    fetch_count,           m_count);
    endtask

    // Advance one cycle: model updates at the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] last_pc;
        int          cycles;

        rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_halted", {31'd0, fetch_halted}, 32'd0);
        check("rst_romaddr", {2'b00, rom_address}, 32'd0);

        rst_n = 1'b1;
        tick();
        check("first_valid", {31'd0, if_valid}, 32'd1);
        check("first_pc", if_pc, 32'h0);
        check("first_instr", if_instruction, 32'h0000_0022);
        tick();
        check("second_pc", if_pc, 32'h4);
        check("second_instr", if_instruction, 32'h2001_0001);
        tick();
        check("word2_pc", if_pc, 32'h8);

        if_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_pc", if_pc, 32'h8);
            check("stall_romaddr", {2'b00, rom_address}, 32'd3);
        end
        if_ready = 1'b1;
        tick();
        check("release_pc", if_pc, 32'hC);
        check("release_count", fetch_count, 32'd3);

        redirect_valid = 1'b1; redirect_target = 32'h0000_0017;
        tick();
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_count", fetch_count, 32'd3);
        redirect_valid = 1'b0;
        tick();
        check("redir_pc", if_pc, 32'h14);
        check("redir_instr", if_instruction, 32'h0041_1820);

        // Run the whole program from reset until halt.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_pc = 32'hDEAD_BEEF;
        cycles = 0;
        while (!fetch_halted && cycles < 100) begin
            tick();
            if (if_valid) last_pc = if_pc;
            cycles++;
        end
        check("halt_reached", {31'd0, fetch_halted}, 32'd1);
        check("last_pc", last_pc, 32'hAC);
        check("halt_count", fetch_count, 32'd44);
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        check("halt_romaddr", {2'b00, rom_address}, 32'd44);
        tick();
        check("halt_hold", {2'b00, rom_address}, 32'd44);

        redirect_valid = 1'b1; redirect_target = 32'h0;
        tick();
        check("resume_halted", {31'd0, fetch_halted}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("resume_pc", if_pc, 32'h0);
        check("resume_instr", if_instruction, 32'h0000_0022);

        // Address wrap at the top of memory.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFA;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_pc_plus4, 32'h0);
        tick();
        check("wrap_pc2", if_pc, 32'h0);

        // Reset in the middle of a stall.
        tick(); tick();
        if_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_pc", if_pc, 32'h0);
        check("mid_rst_instr", if_instruction, 32'h0);
        check("mid_rst_count", fetch_count, 32'd0);
        check("mid_rst_romaddr", {2'b00, rom_address}, 32'd0);
        rst_n = 1'b1; if_ready = 1'b1;
        tick();
        check("restart_pc", if_pc, 32'h0);
        check("restart_valid", {31'd0, if_valid}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = $urandom_range(0, 200);
                1:       redirect_target = 32'hFFFF_FF00 + $urandom_range(0, 255);
                2:       redirect_target = $urandom;
                default: redirect_target = $urandom_range(160, 190);
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
